wishbone_cmd_master: RTL and testbench
======================================

# wishbone_cmd_master

Single-transaction Wishbone master that turns simple command requests into Wishbone read/write cycles. It issues commands from an upstream source (debug UART command decoder, test sequencer) to the Wishbone slaves on the bus, such as the LED port slave. It returns read data or an error status through a response handshake. The bus is guarded by a timeout, so an absent or stuck slave cannot hang the command path.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max cycles waited for ack assertion (BUS) and for ack release (DRAIN); legal range 1..65535

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- cmd_valid_i  input  1  upstream command present
- cmd_ready_o  output  1  master accepts command; high only in IDLE
- cmd_we_i  input  1  1 = write, 0 = read
- cmd_addr_i  input  32  target address
- cmd_data_i  input  32  write data (ignored for reads)
- rsp_valid_o  output  1  response available; held until accepted
- rsp_ready_i  input  1  upstream accepts response
- rsp_data_o  output  32  read data; 0 for writes and errors
- rsp_err_o  output  1  1 = timeout occurred
- addr_o  output  32  Wishbone address
- we_o  output  1  Wishbone write enable
- data_o  output  32  Wishbone write data
- cyc_o  output  1  Wishbone cycle
- stb_o  output  1  Wishbone strobe; always equal to cyc_o
- data_i  input  32  Wishbone read data
- ack_i  input  1  Wishbone acknowledge; slaves may hold it high until cyc/stb drop

## Operation
- State machine: IDLE, BUS, DRAIN, RESP. All outputs except cmd_ready_o are registered. cmd_ready_o = (state == IDLE).
- IDLE: when cmd_valid_i is sampled high, the master:
  - latches cmd_addr_i into addr_o, cmd_data_i into data_o and cmd_we_i into we_o;
  - sets cyc_o/stb_o = 1 and clears the timeout counter;
  - moves to BUS.
- BUS: addr_o, data_o and we_o are stable while cyc_o = 1.
  - ack_i sampled 1: capture data_i into rsp_data_o on a read; load 0 on a write. Set rsp_err_o = 0, clear cyc_o/stb_o/we_o, clear the counter, go to DRAIN.
  - ack_i sampled 0: increment the counter. When the counter reaches TIMEOUT_CYCLES, set rsp_err_o = 1 and rsp_data_o = 0, clear cyc_o/stb_o/we_o and the counter, go to DRAIN.
- DRAIN: waits for the slave to release ack.
  - ack_i sampled 0: set rsp_valid_o = 1, go to RESP.
  - Otherwise increment the counter. On reaching TIMEOUT_CYCLES, set rsp_err_o = 1, rsp_data_o = 0, rsp_valid_o = 1, go to RESP.
- RESP: rsp_valid_o, rsp_data_o and rsp_err_o are held stable. When rsp_ready_i is sampled high, clear rsp_valid_o and go to IDLE. rsp_data_o and rsp_err_o keep their values until the next response is loaded.
- addr_o and data_o keep their last values outside BUS. we_o is 0 whenever cyc_o is 0.
- The counter is 16 bits and never wraps, because it is cleared on every state entry that uses it.
- Exactly one outstanding transaction at a time. There are no bursts and no pipelining; sel/cti signals are not used.

## Timing
- Reset (asynchronous, applies immediately, including mid-transaction):
  - state IDLE;
  - cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o = 0;
  - addr_o, data_o, rsp_data_o = 0;
  - cmd_ready_o = 1 once rst_i is low.
- Command accepted at edge E0: cyc_o/stb_o are high in the cycle after E0.
- Zero-wait slave (ack in the first cyc cycle): ack sampled at E1, cyc_o low after E1, ack low sampled at E2, rsp_valid_o high after E2. Minimum command-to-response latency is 2 cycles.
- A slave that registers ack (ack one cycle after stb) adds 1 cycle, giving 3.
- Each wait cycle adds 1 cycle.
- cyc_o deasserts exactly 1 cycle after the edge that sampled ack_i = 1.
- Timeout in BUS: cyc_o is high for exactly TIMEOUT_CYCLES cycles. rsp_valid_o rises no earlier than TIMEOUT_CYCLES + 1 cycles after the first cyc_o cycle.
- A new command is accepted no sooner than 1 cycle after the response handshake, because cmd_ready_o goes high in IDLE.
- Upstream holding rsp_ready_i high completes the response in its first valid cycle.

## Test plan
- Read from a zero-wait slave returning 32'hDEADBEEF: cmd_valid at addr 32'h0000_1000 -> cyc/stb high 1 cycle; rsp_valid 2 cycles after accept; rsp_data 32'hDEADBEEF; rsp_err 0.
- Write 32'h0000_002A to a level-ack slave (ack held until cyc drops, one-cycle registered ack) -> we_o/data_o stable while cyc high; cyc high 2 cycles; rsp_data 0; rsp_err 0; slave register holds 32'h2A.
- No slave response, TIMEOUT_CYCLES = 16 -> cyc high exactly 16 cycles; rsp_err 1; rsp_data 0; next command accepted normally.
- ack_i stuck high after cyc drops -> DRAIN times out after 16 cycles; rsp_valid with rsp_err 1.
- rsp_ready_i held low 5 cycles -> rsp_valid and rsp_data stable all 5 cycles; cmd_ready_o low throughout; second command accepted only after the handshake.
- rst_i pulsed mid-BUS (cyc high, wait-state slave) -> cyc_o/stb_o/we_o drop in the same cycle without a clock edge; rsp_valid never asserts; the next command completes correctly.

Source files
------------

// File: rtl/wishbone_cmd_master.sv
// Single-outstanding Wishbone master: turns command handshakes into classic
// read/write cycles and returns data or a timeout error through a response handshake.
module wishbone_cmd_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic [31:0] addr_o,
   output logic        we_o,
   output logic [31:0] data_o,
   output logic        cyc_o,
   output logic        stb_o,
   input  logic [31:0] data_i,
   input  logic        ack_i
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready_o high
   // BUS   | cyc/stb asserted, waiting for ack or timeout
   // DRAIN | cycle closed, waiting for slave to release ack or timeout
   // RESP  | response presented, waiting for rsp_ready_i
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Counter compares against TIMEOUT_CYCLES-1 so the terminal edge is the
   // TIMEOUT_CYCLES-th sample of the waiting state.
   localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic        r_cyc, w_cyc_nxt;
   logic        r_we, w_we_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_data, w_data_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0] r_rsp_data, w_rsp_data_nxt;
   logic        r_rsp_err, w_rsp_err_nxt;
   logic        w_cnt_done;

   assign w_cnt_done = (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_cyc       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cyc       <= w_cyc_nxt;
         r_we        <= w_we_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_cyc_nxt       = r_cyc;
      w_we_nxt        = r_we;
      w_addr_nxt      = r_addr;
      w_data_nxt      = r_data;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_data_nxt  = r_rsp_data;
      w_rsp_err_nxt   = r_rsp_err;
      case (r_state)
         IDLE: begin
            if (cmd_valid_i) begin
               w_addr_nxt  = cmd_addr_i;
               w_data_nxt  = cmd_data_i;
               w_we_nxt    = cmd_we_i;
               w_cyc_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = BUS;
            end
         end
         BUS: begin
            if (ack_i) begin
               w_rsp_data_nxt = r_we ? 32'd0 : data_i;
               w_rsp_err_nxt  = 1'b0;
               w_cyc_nxt      = 1'b0;
               w_we_nxt       = 1'b0;
               w_cnt_nxt      = '0;
               w_state_nxt    = DRAIN;
            end else if (w_cnt_done) begin
               w_rsp_data_nxt = '0;
               w_rsp_err_nxt  = 1'b1;
               w_cyc_nxt      = 1'b0;
               w_we_nxt       = 1'b0;
               w_cnt_nxt      = '0;
               w_state_nxt    = DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         DRAIN: begin
            if (!ack_i) begin
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = RESP;
            end else if (w_cnt_done) begin
               w_rsp_data_nxt  = '0;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = RESP;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign cmd_ready_o = (r_state == IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;
   assign addr_o      = r_addr;
   assign data_o      = r_data;
   assign we_o        = r_we;
   assign cyc_o       = r_cyc;
   assign stb_o       = r_cyc;

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Directed bench for wishbone_cmd_master with a small behavioural Wishbone slave
// whose ack behaviour is selected per step.
module tb_wishbone_cmd_master;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_addr_i = '0;
   logic [31:0] cmd_data_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic [31:0] addr_o;
   logic        we_o;
   logic [31:0] data_o;
   logic        cyc_o;
   logic        stb_o;
   logic [31:0] data_i;
   logic        ack_i;

   // slave modes: 0 silent, 1 zero-wait, 2 registered level ack, 3 ack stuck high
   int          mode = 0;
   logic [31:0] s_rd_data = '0;
   logic [31:0] s_reg;
   logic        s_seen;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   wishbone_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .addr_o(addr_o), .we_o(we_o), .data_o(data_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .data_i(data_i), .ack_i(ack_i)
   );

   assign data_i = s_rd_data;

   always_comb begin
      ack_i = 1'b0;
      case (mode)
         1:       ack_i = cyc_o & stb_o;
         2:       ack_i = cyc_o & stb_o & s_seen;
         3:       ack_i = 1'b1;
         default: ack_i = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      s_seen <= cyc_o & stb_o;
      if (cyc_o && stb_o && ack_i && we_o) s_reg <= data_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int  n;
      bit  seen_valid;

      // reset state
      tick(); tick();
      check("rst_cyc", cyc_o, 0);
      check("rst_stb", stb_o, 0);
      check("rst_we", we_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_err", rsp_err_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_data", data_o, 0);
      check("rst_rsp_data", rsp_data_o, 0);
      rst_i = 1'b0;
      tick();
      check("idle_ready", cmd_ready_o, 1);

      // read from zero-wait slave
      mode = 1; s_rd_data = 32'hDEADBEEF;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_1000;
      tick();
      cmd_valid_i = 1'b0;
      check("rd_cyc", cyc_o, 1);
      check("rd_stb", stb_o, 1);
      check("rd_addr", addr_o, 32'h0000_1000);
      check("rd_ready_low", cmd_ready_o, 0);
      tick();
      check("rd_cyc_drop", cyc_o, 0);
      check("rd_no_valid_yet", rsp_valid_o, 0);
      tick();
      check("rd_valid", rsp_valid_o, 1);
      check("rd_data", rsp_data_o, 32'hDEADBEEF);
      check("rd_err", rsp_err_o, 0);
      tick();
      check("rd_valid_clr", rsp_valid_o, 0);
      check("rd_ready_back", cmd_ready_o, 1);

      // write to registered level-ack slave
      mode = 2;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h0000_2000; cmd_data_i = 32'h0000_002A;
      tick();
      cmd_valid_i = 1'b0; cmd_data_i = 32'h0;
      check("wr_cyc1", cyc_o, 1);
      check("wr_we1", we_o, 1);
      check("wr_data1", data_o, 32'h2A);
      tick();
      check("wr_cyc2", cyc_o, 1);
      check("wr_we2", we_o, 1);
      check("wr_data2", data_o, 32'h2A);
      check("wr_addr2", addr_o, 32'h0000_2000);
      tick();
      check("wr_cyc_drop", cyc_o, 0);
      check("wr_we_drop", we_o, 0);
      check("wr_slave_reg", s_reg, 32'h2A);
      tick();
      check("wr_valid", rsp_valid_o, 1);
      check("wr_rsp_data", rsp_data_o, 0);
      check("wr_err", rsp_err_o, 0);
      tick();
      check("wr_done", rsp_valid_o, 0);

      // no slave: BUS timeout
      mode = 0;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_3000;
      tick();
      cmd_valid_i = 1'b0;
      n = 0;
      while (cyc_o && n < 40) begin n++; tick(); end
      check("to_cyc_cycles", n, 16);
      check("to_no_valid_yet", rsp_valid_o, 0);
      tick();
      check("to_valid", rsp_valid_o, 1);
      check("to_err", rsp_err_o, 1);
      check("to_data", rsp_data_o, 0);
      tick();
      mode = 1; s_rd_data = 32'h1234_5678;
      cmd_valid_i = 1'b1; cmd_addr_i = 32'h0000_3004;
      tick();
      cmd_valid_i = 1'b0;
      check("to_next_cyc", cyc_o, 1);
      tick(); tick();
      check("to_next_valid", rsp_valid_o, 1);
      check("to_next_data", rsp_data_o, 32'h1234_5678);
      check("to_next_err", rsp_err_o, 0);
      tick();

      // ack stuck high: DRAIN timeout
      mode = 3; s_rd_data = 32'hCAFE_0000;
      cmd_valid_i = 1'b1; cmd_addr_i = 32'h0000_4000;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      check("stk_cyc_drop", cyc_o, 0);
      n = 0;
      while (!rsp_valid_o && n < 40) begin n++; tick(); end
      check("stk_drain_cycles", n, 16);
      check("stk_valid", rsp_valid_o, 1);
      check("stk_err", rsp_err_o, 1);
      check("stk_data", rsp_data_o, 0);
      tick();
      mode = 1;
      tick();

      // upstream back-pressure on response
      rsp_ready_i = 1'b0; s_rd_data = 32'hA5A5_0001;
      cmd_valid_i = 1'b1; cmd_addr_i = 32'h0000_5000;
      tick();
      cmd_addr_i = 32'h0000_5004;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", rsp_valid_o, 1);
         check("bp_data", rsp_data_o, 32'hA5A5_0001);
         check("bp_ready_low", cmd_ready_o, 0);
         check("bp_no_cyc", cyc_o, 0);
         tick();
      end
      rsp_ready_i = 1'b1;
      tick();
      check("bp_valid_clr", rsp_valid_o, 0);
      check("bp_not_yet_accepted", cyc_o, 0);
      s_rd_data = 32'hBEEF_0002;
      tick();
      cmd_valid_i = 1'b0;
      check("bp_second_cyc", cyc_o, 1);
      check("bp_second_addr", addr_o, 32'h0000_5004);
      tick(); tick();
      check("bp_second_data", rsp_data_o, 32'hBEEF_0002);
      tick();

      // async reset mid-BUS
      mode = 0;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h0000_6000; cmd_data_i = 32'h55;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      check("mr_cyc_before", cyc_o, 1);
      #2 rst_i = 1'b1;
      #1;
      check("mr_cyc", cyc_o, 0);
      check("mr_stb", stb_o, 0);
      check("mr_we", we_o, 0);
      #1 rst_i = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rsp_valid_o) seen_valid = 1'b1;
      end
      check("mr_no_valid", seen_valid, 0);
      mode = 1; s_rd_data = 32'h0BAD_F00D;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_7000;
      tick();
      cmd_valid_i = 1'b0;
      tick(); tick();
      check("mr_after_valid", rsp_valid_o, 1);
      check("mr_after_data", rsp_data_o, 32'h0BAD_F00D);
      check("mr_after_err", rsp_err_o, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
